seq_shift_gen: RTL and testbench

Parametrised shift-sequence generator and the successor to the fixed 8-bit twisted-ring counter in the Tiny Tapeout user design. It produces Johnson, one-hot ring or maximal-length LFSR sequences of configurable width, with:
- a programmable step-rate prescaler;
- direction control;
- parallel load;
- free-run or one-shot (single period) operation.

It sits behind `tt_um_*` top-level pin mapping and drives `uo_out`/`uio_out` directly or feeds other blocks.

---
 rtl/seq_gen_pkg.sv | 21 ++
 rtl/seq_prescaler.sv | 50 +++++
 rtl/seq_shift_gen.sv | 184 ++++++++++++++++++
 tb/tb_seq_shift_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the shift-sequence generator.
//   mode_e  : sequence family selected at start
//   state_e : control FSM states
//   DEFAULT_TAPS : maximal-length Galois tap mask for an 8-bit register
package seq_gen_pkg;

    typedef enum logic [1:0] {
        MODE_JOHNSON = 2'd0,
        MODE_RING    = 2'd1,
        MODE_LFSR    = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ONESHOT = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

endpackage : seq_gen_pkg

// File: rtl/seq_prescaler.sv
// Step-rate prescaler: asserts tick once every div+1 enabled cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous counter clear (start of a run)
//   en         : count enable (generator busy and globally enabled)
//   div        : divide value, sampled live
//   tick       : combinational step qualifier, en & (cnt == div)
module seq_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Tick when the count reaches div; a count above a newly lowered div
    // simply runs on and wraps through zero before it can match again.
    always_comb begin
        tick  = en & (cnt_q == div);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (en) begin
            if (tick) begin
                cnt_d = {DIV_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : seq_prescaler

// File: rtl/seq_shift_gen.sv
// Parametrised Johnson / ring / Galois-LFSR sequence generator with
// prescaler, direction control, parallel load and one-shot operation.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : global enable; low freezes every piece of state
//   mode, dir   : sequence family and shift direction, latched at start
//   div         : step every div+1 enabled cycles (live)
//   start/oneshot/stop : run control
//   load, load_data    : parallel load, honoured only while idle
//   seq_out     : sequence register
//   tick        : combinational step qualifier
//   wrap, done  : registered pulses (return to origin, end of one-shot)
//   busy        : generator not idle
module seq_shift_gen
    import seq_gen_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DIV_W     = 8,
    parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             start,
    input  logic             oneshot,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] seq_out,
    output logic             tick,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [WIDTH-1:0] origin_q, origin_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             presc_clear;
    logic             presc_en;
    logic             tick_s;
    logic [WIDTH-1:0] step_val;

    // One step of the selected sequence. The reserved mode code falls into
    // the Johnson branch; LFSR ignores dir.
    function automatic logic [WIDTH-1:0] next_seq(
        input logic [WIDTH-1:0] q,
        input logic [1:0]       m,
        input logic             d
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_RING: begin
                if (d) begin
                    r = {q[0], q[WIDTH-1:1]};
                end else begin
                    r = {q[WIDTH-2:0], q[WIDTH-1]};
                end
            end
            MODE_LFSR: begin
                r = (q >> 1) ^ (q[0] ? LFSR_TAPS : {WIDTH{1'b0}});
            end
            default: begin
                if (d) begin
                    r = {~q[0], q[WIDTH-1:1]};
                end else begin
                    r = {q[WIDTH-2:0], ~q[WIDTH-1]};
                end
            end
        endcase
        return r;
    endfunction

    assign presc_en = busy_q & ena;

    seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .en    (presc_en),
        .div   (div),
        .tick  (tick_s)
    );

    // Control FSM and datapath next-state; stop always beats start and tick.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        origin_d    = origin_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        presc_clear = 1'b0;
        step_val    = next_seq(seq_q, mode_q, dir_q);

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        seq_d = load_data;
                    end else begin
                        seq_d = seq_q;
                    end
                    if (start && !stop) begin
                        state_d     = oneshot ? ST_ONESHOT : ST_RUN;
                        mode_d      = mode;
                        dir_d       = dir;
                        origin_d    = load ? load_data : seq_q;
                        presc_clear = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN, ST_ONESHOT: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (tick_s) begin
                        seq_d = step_val;
                        if (step_val == origin_q) begin
                            wrap_d = 1'b1;
                            if (state_q == ST_ONESHOT) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = state_q;
                            end
                        end else begin
                            wrap_d = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            seq_q    <= {WIDTH{1'b0}};
            origin_q <= {WIDTH{1'b0}};
            mode_q   <= 2'd0;
            dir_q    <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            origin_q <= origin_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign seq_out = seq_q;
    assign tick    = tick_s;
    assign wrap    = wrap_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule : seq_shift_gen

// File: tb/tb_seq_shift_gen.sv
// Directed self-checking bench for seq_shift_gen (WIDTH=8, DIV_W=8, taps 0xB8).
module tb_seq_shift_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       dir = 1'b0;
    logic [7:0] div = 8'd0;
    logic       start = 1'b0;
    logic       oneshot = 1'b0;
    logic       stop = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_data = 8'd0;
    logic [7:0] seq_out;
    logic       tick;
    logic       wrap;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    seq_shift_gen #(
        .WIDTH     (8),
        .DIV_W     (8),
        .LFSR_TAPS (8'hB8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .mode      (mode),
        .dir       (dir),
        .div       (div),
        .start     (start),
        .oneshot   (oneshot),
        .stop      (stop),
        .load      (load),
        .load_data (load_data),
        .seq_out   (seq_out),
        .tick      (tick),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] johnson_tab [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                     8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0] model;
    logic [7:0] exp_v;
    bit         seen [256];
    int         distinct;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) step();
        check_eq("rst_seq",  seq_out,     8'h00);
        check_eq("rst_busy", 8'(busy),    8'h00);
        check_eq("rst_tick", 8'(tick),    8'h00);
        check_eq("rst_wrap", 8'(wrap),    8'h00);
        check_eq("rst_done", 8'(done),    8'h00);
        rst_n = 1'b1;
        step();

        // ---------------- Johnson free-run, dir=0, div=0 ----------------
        mode = 2'd0; dir = 1'b0; div = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("jn_busy_start", 8'(busy), 8'h01);
        check_eq("jn_seq_start",  seq_out,  8'h00);
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("jn_seq",  seq_out,  johnson_tab[i]);
            check_eq("jn_wrap", 8'(wrap), (i == 15) ? 8'h01 : 8'h00);
        end
        check_eq("jn_busy_after_wrap", 8'(busy), 8'h01);
        step();
        check_eq("jn_seq_17",  seq_out,  8'h01);
        check_eq("jn_wrap_17", 8'(wrap), 8'h00);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("jn_stop_busy", 8'(busy), 8'h00);
        check_eq("jn_stop_seq",  seq_out,  8'h01);

        // ---------------- Johnson dir=1 from zero ----------------
        load = 1'b1; load_data = 8'h00;
        step();
        load = 1'b0;
        check_eq("load_zero", seq_out, 8'h00);
        dir = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); check_eq("jd1_s1", seq_out, 8'h80);
        step(); check_eq("jd1_s2", seq_out, 8'hC0);
        step(); check_eq("jd1_s3", seq_out, 8'hE0);
        check_eq("jd1_tick_pending", 8'(tick), 8'h01);
        // stop coincides with a tick: no step
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("stop_tick_seq",  seq_out,  8'hE0);
        check_eq("stop_tick_busy", 8'(busy), 8'h00);
        dir = 1'b0;

        // ---------------- Ring one-shot, div=2 ----------------
        mode = 2'd1; div = 8'd2; load = 1'b1; load_data = 8'h01;
        start = 1'b1; oneshot = 1'b1;
        step();
        load = 1'b0; start = 1'b0; oneshot = 1'b0;
        check_eq("ring_load_seq", seq_out,  8'h01);
        check_eq("ring_busy",     8'(busy), 8'h01);
        for (int k = 1; k <= 8; k++) begin
            step(); step();
            check_eq("ring_tick", 8'(tick), 8'h01);
            step();
            exp_v = 8'h01 << k;
            if (k == 8) exp_v = 8'h01;
            check_eq("ring_seq",  seq_out,  exp_v);
            check_eq("ring_done", 8'(done), (k == 8) ? 8'h01 : 8'h00);
            check_eq("ring_wrap", 8'(wrap), (k == 8) ? 8'h01 : 8'h00);
            check_eq("ring_busy", 8'(busy), (k == 8) ? 8'h00 : 8'h01);
        end
        step();
        check_eq("ring_done_pulse", 8'(done), 8'h00);
        check_eq("ring_tick_idle",  8'(tick), 8'h00);

        // ---------------- LFSR one-shot, div=0 ----------------
        mode = 2'd2; div = 8'd0; load = 1'b1; load_data = 8'h01;
        start = 1'b1; oneshot = 1'b1;
        step();
        load = 1'b0; start = 1'b0; oneshot = 1'b0;
        check_eq("lfsr_seed", seq_out, 8'h01);
        model = 8'h01;
        distinct = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            if (i == 10) begin
                load = 1'b1; load_data = 8'h55;
            end
            step();
            load = 1'b0;
            model = {1'b0, model[7:1]} ^ (model[0] ? 8'hB8 : 8'h00);
            check_eq("lfsr_seq",  seq_out,  model);
            check_eq("lfsr_done", 8'(done), (i == 255) ? 8'h01 : 8'h00);
            if (seq_out != 8'h00 && !seen[seq_out]) begin
                seen[seq_out] = 1'b1;
                distinct++;
            end
        end
        check_eq("lfsr_distinct", 8'(distinct), 8'd255);
        check_eq("lfsr_end_seq",  seq_out,      8'h01);
        check_eq("lfsr_end_busy", 8'(busy),     8'h00);
        check_eq("lfsr_end_wrap", 8'(wrap),     8'h01);

        // ---------------- start & stop together ----------------
        mode = 2'd0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_eq("startstop_busy", 8'(busy), 8'h00);
        step();
        check_eq("startstop_seq",  seq_out,  8'h01);

        // ---------------- ena low mid-run, then stop ----------------
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_eq("ena_pre_seq", seq_out, 8'h03);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("ena_low_tick", 8'(tick), 8'h00);
            check_eq("ena_low_seq",  seq_out,  8'h03);
            check_eq("ena_low_busy", 8'(busy), 8'h01);
        end
        ena = 1'b1;
        step();
        check_eq("ena_resume_seq", seq_out, 8'h07);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("midstop_busy", 8'(busy), 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("midstop_seq",  seq_out,  8'h07);
            check_eq("midstop_wrap", 8'(wrap), 8'h00);
        end

        // ---------------- async reset mid one-shot ----------------
        mode = 2'd1; load = 1'b1; load_data = 8'h01; start = 1'b1; oneshot = 1'b1;
        step();
        load = 1'b0; start = 1'b0; oneshot = 1'b0;
        step();
        check_eq("os_pre_rst_seq", seq_out, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_seq",  seq_out,  8'h00);
        check_eq("arst_busy", 8'(busy), 8'h00);
        check_eq("arst_tick", 8'(tick), 8'h00);
        check_eq("arst_wrap", 8'(wrap), 8'h00);
        check_eq("arst_done", 8'(done), 8'h00);
        #2 rst_n = 1'b1;
        step();
        check_eq("post_rst_busy", 8'(busy), 8'h00);
        mode = 2'd0; dir = 1'b0; div = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        check_eq("post_rst_start_busy", 8'(busy), 8'h01);
        step();
        check_eq("post_rst_seq", seq_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_shift_gen
